// File: rtl/ws2812b_driver_if.sv
// LED ring control bundle: refresh enable, per-LED mask and intensity in; NRZ line and status out.
// Pure wiring; outputs are registered in the driver and there is no backpressure path.
interface ws2812b_driver_if #(
  parameter int NUM_LEDS = 12
);
  logic                en;
  logic [NUM_LEDS-1:0] led_mask;
  logic [7:0]          intensity;
  logic                dout;
  logic                busy;
  logic                frame_done;

  modport master (
    output en, led_mask, intensity,
    input  dout, busy, frame_done
  );

  modport slave (
    input  en, led_mask, intensity,
    output dout, busy, frame_done
  );
endinterface

// File: rtl/ws2812b_driver.sv
// Continuous WS2812B ring refresh: latch gap, one-cycle snapshot, then NUM_LEDS*24 bit periods.
// All outputs registered (one cycle behind the state decision); inputs only sampled at LOAD.
module ws2812b_driver #(
  parameter int         NUM_LEDS = 12,
  parameter int         T_BIT    = 50,
  parameter int         T0H      = 16,
  parameter int         T1H      = 32,
  parameter int         T_LATCH  = 2400,
  parameter logic [2:0] COLOR_EN = 3'b111
) (
  input  logic            clk_i,
  input  logic            res_n_i,
  ws2812b_driver_if.slave bus
);

  localparam int CYC_W = $clog2(T_BIT);
  localparam int LAT_W = $clog2(T_LATCH + 1);
  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_LATCH - 1);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
  localparam logic [4:0]       BIT_LAST = 5'd23;

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
    $error("ws2812b_driver: need 0 < T0H < T1H < T_BIT");
  end

  typedef enum logic [1:0] {
    S_LATCH,
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [4:0]          bit_q, bit_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [7:0]          int_q, int_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                ch_en;
  logic [7:0]          byte_v;
  logic                cur_bit;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    led_d   = led_q;
    mask_d  = mask_q;
    int_d   = int_q;
    done_d  = 1'b0;
    ch_en   = 1'b0;
    byte_v  = 8'h00;
    cur_bit = 1'b0;

    case (state_q)
      S_LATCH: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = bus.en ? S_LOAD : S_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.en) state_d = S_LOAD;
      end
      S_LOAD: begin
        mask_d  = bus.led_mask;
        int_d   = bus.intensity;
        led_d   = '0;
        bit_d   = '0;
        cyc_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (led_q == LED_LAST) begin
              led_d   = '0;
              done_d  = 1'b1;
              state_d = S_LATCH;
            end else begin
              led_d = led_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = S_LATCH;
    endcase

    // Decode the bit for the upcoming period so dout can be registered without a pipeline lag.
    case (bit_d[4:3])
      2'd0:    ch_en = COLOR_EN[2];
      2'd1:    ch_en = COLOR_EN[1];
      default: ch_en = COLOR_EN[0];
    endcase
    byte_v  = (mask_d[led_d] && ch_en) ? int_d : 8'h00;
    cur_bit = byte_v[~bit_d[2:0]];

    busy_d = (state_d == S_LOAD) || (state_d == S_SEND);
    dout_d = (state_d == S_SEND) && (cyc_d < (cur_bit ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q <= S_LATCH;
      lat_q   <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      led_q   <= '0;
      mask_q  <= '0;
      int_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      mask_q  <= mask_d;
      int_q   <= int_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ws2812b_driver.sv
// Bench for ws2812b_driver: a 12-LED ring instance and a 2-LED red-only instance, bit widths
// measured on dout and compared against widths computed from the colour/bit-order rules.
module tb_ws2812b_driver;
  localparam int T_BIT   = 50;
  localparam int T0H     = 16;
  localparam int T1H     = 32;
  localparam int T_LATCH = 2400;
  localparam int NBITS   = 288;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  ws2812b_driver_if #(.NUM_LEDS(12)) bus_a ();
  ws2812b_driver_if #(.NUM_LEDS(2))  bus_b ();

  ws2812b_driver #(.NUM_LEDS(12)) u_dut_a (
    .clk_i  (clk),
    .res_n_i(res_n),
    .bus    (bus_a)
  );

  ws2812b_driver #(.NUM_LEDS(2), .COLOR_EN(3'b010)) u_dut_b (
    .clk_i  (clk),
    .res_n_i(res_n),
    .bus    (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wid[NBITS];
  bit shape_bad, early_done, done_seen, tmo, hi_in_wait;
  int wait_cyc;
  logic [11:0] rnd_mask;
  logic [7:0]  rnd_int;

  function automatic logic get_dout(input int which);
    return (which == 0) ? bus_a.dout : bus_b.dout;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  function automatic logic get_done(input int which);
    return (which == 0) ? bus_a.frame_done : bus_b.frame_done;
  endfunction

  // Expected high time of frame bit b: LED b/24, channel G,R,B, MSB first.
  function automatic int exp_width(input int b, input logic [11:0] mask, input logic [7:0] inten,
                                   input logic [2:0] cen);
    int led, ch, pos;
    logic [7:0] byt;
    led = b / 24;
    ch  = (b % 24) / 8;
    pos = 7 - (b % 8);
    byt = (mask[led] && cen[2-ch]) ? inten : 8'h00;
    return byt[pos] ? T1H : T0H;
  endfunction

  task automatic apply_action(input int act);
    case (act)
      1: bus_a.led_mask = 12'h800;
      2: begin bus_a.led_mask = 12'hFFF; bus_a.intensity = 8'hFF; end
      3: bus_a.en = 1'b0;
      default: ;
    endcase
  endtask

  task automatic wait_busy(input int which, input int limit);
    wait_cyc = 0; tmo = 1'b0; hi_in_wait = 1'b0;
    while (get_busy(which) !== 1'b1) begin
      @(negedge clk);
      wait_cyc++;
      if (get_dout(which) !== 1'b0) hi_in_wait = 1'b1;
      if (wait_cyc > limit) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  // Starts on the LOAD-cycle negedge; records the high time of each bit period.
  task automatic capture(input int which, input int nbits, input int act_bit, input int act);
    shape_bad = 1'b0; early_done = 1'b0; done_seen = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      int hi;
      bit seen_low;
      if (b == act_bit) apply_action(act);
      hi = 0;
      seen_low = 1'b0;
      for (int c = 0; c < T_BIT; c++) begin
        @(negedge clk);
        if (get_done(which) !== 1'b0) early_done = 1'b1;
        if (get_dout(which) === 1'b1) begin
          if (seen_low) shape_bad = 1'b1;
          hi++;
        end else begin
          seen_low = 1'b1;
        end
      end
      wid[b] = hi;
    end
    @(negedge clk);
    done_seen = (get_done(which) === 1'b1);
  endtask

  task automatic test_reset;
    bus_a.en = 1'b1; bus_a.led_mask = 12'h001; bus_a.intensity = 8'h20;
    bus_b.en = 1'b1; bus_b.led_mask = 2'b11;   bus_b.intensity = 8'h81;
    res_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_a.dout !== 1'b0) begin n_bad++; $display("FAIL reset_dout: got %b want 0", bus_a.dout); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    n_cmp++; if (bus_a.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus_a.frame_done); end
    res_n = 1'b1;
    wait_busy(0, T_LATCH + 100);
    n_cmp++; if (tmo || wait_cyc != T_LATCH) begin n_bad++; $display("FAIL reset_latch_len: got %0d want %0d (timeout %b)", wait_cyc, T_LATCH, tmo); end
    n_cmp++; if (hi_in_wait) begin n_bad++; $display("FAIL reset_latch_low: dout high during latch, want low"); end
  endtask

  task automatic test_single_led;
    capture(0, NBITS, 100, 1);
    for (int b = 0; b < NBITS; b++) begin
      n_cmp++;
      if (wid[b] != exp_width(b, 12'h001, 8'h20, 3'b111)) begin
        n_bad++; $display("FAIL single_led_bit%0d: high %0d want %0d", b, wid[b], exp_width(b, 12'h001, 8'h20, 3'b111));
      end
    end
    n_cmp++; if (shape_bad) begin n_bad++; $display("FAIL single_led_shape: high after low in a bit, want one pulse"); end
    n_cmp++; if (early_done) begin n_bad++; $display("FAIL single_led_early_done: pulse inside frame, want none"); end
    n_cmp++; if (!done_seen) begin n_bad++; $display("FAIL single_led_done: got 0 at 1+14400, want 1"); end
  endtask

  task automatic test_back_to_back;
    wait_busy(0, T_LATCH + 100);
    n_cmp++; if (tmo || wait_cyc != T_LATCH) begin n_bad++; $display("FAIL gap1_len: got %0d want %0d", wait_cyc, T_LATCH); end
    n_cmp++; if (hi_in_wait) begin n_bad++; $display("FAIL gap1_low: dout high in gap, want low"); end
    capture(0, NBITS, 100, 2);
    for (int b = 0; b < NBITS; b++) begin
      n_cmp++;
      if (wid[b] != exp_width(b, 12'h800, 8'h20, 3'b111)) begin
        n_bad++; $display("FAIL mask_change_bit%0d: high %0d want %0d", b, wid[b], exp_width(b, 12'h800, 8'h20, 3'b111));
      end
    end
    n_cmp++; if (shape_bad || early_done || !done_seen) begin n_bad++; $display("FAIL mask_change_frame: shape %b early %b done %b want 0 0 1", shape_bad, early_done, done_seen); end
    wait_busy(0, T_LATCH + 100);
    n_cmp++; if (tmo || wait_cyc != T_LATCH) begin n_bad++; $display("FAIL gap2_len: got %0d want %0d", wait_cyc, T_LATCH); end
  endtask

  task automatic test_en_drop;
    int busy_cnt, hi_cnt;
    capture(0, NBITS, 50, 3);
    for (int b = 0; b < NBITS; b++) begin
      n_cmp++;
      if (wid[b] != exp_width(b, 12'hFFF, 8'hFF, 3'b111)) begin
        n_bad++; $display("FAIL full_bit%0d: high %0d want %0d", b, wid[b], T1H);
      end
    end
    n_cmp++; if (shape_bad || early_done || !done_seen) begin n_bad++; $display("FAIL en_drop_frame: shape %b early %b done %b want 0 0 1", shape_bad, early_done, done_seen); end
    busy_cnt = 0; hi_cnt = 0;
    repeat (T_LATCH + 200) begin
      @(negedge clk);
      if (bus_a.busy !== 1'b0) busy_cnt++;
      if (bus_a.dout !== 1'b0) hi_cnt++;
    end
    n_cmp++; if (busy_cnt != 0) begin n_bad++; $display("FAIL idle_busy: busy cycles %0d want 0", busy_cnt); end
    n_cmp++; if (hi_cnt != 0) begin n_bad++; $display("FAIL idle_dout: high cycles %0d want 0", hi_cnt); end
    bus_a.en = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL idle_restart: busy %b want 1", bus_a.busy); end
  endtask

  task automatic test_reset_mid_frame;
    repeat (60) @(negedge clk);
    n_cmp++; if (bus_a.dout !== 1'b1) begin n_bad++; $display("FAIL midframe_high: dout %b want 1", bus_a.dout); end
    #2 res_n = 1'b0;
    #1;
    n_cmp++; if (bus_a.dout !== 1'b0) begin n_bad++; $display("FAIL async_reset_dout: got %b want 0", bus_a.dout); end
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b want 0", bus_a.busy); end
    rnd_mask = 12'($urandom_range(0, 4095));
    rnd_int  = 8'($urandom_range(0, 255));
    bus_a.led_mask = rnd_mask;
    bus_a.intensity = rnd_int;
    @(negedge clk);
    res_n = 1'b1;
    wait_busy(0, T_LATCH + 100);
    n_cmp++; if (tmo || wait_cyc != T_LATCH) begin n_bad++; $display("FAIL rereset_latch_len: got %0d want %0d", wait_cyc, T_LATCH); end
    capture(0, 48, -1, 0);
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (wid[b] != exp_width(b, rnd_mask, rnd_int, 3'b111)) begin
        n_bad++; $display("FAIL random_bit%0d: high %0d want %0d (mask %h int %h)", b, wid[b], exp_width(b, rnd_mask, rnd_int, 3'b111), rnd_mask, rnd_int);
      end
    end
    n_cmp++; if (shape_bad) begin n_bad++; $display("FAIL random_shape: high after low in a bit, want one pulse"); end
  endtask

  task automatic test_small_chain;
    int guard;
    guard = 0;
    while (bus_b.frame_done !== 1'b1 && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++; if (guard >= 6000) begin n_bad++; $display("FAIL small_sync: no frame_done in %0d cycles, want one", guard); end
    wait_busy(1, T_LATCH + 100);
    n_cmp++; if (tmo || wait_cyc != T_LATCH) begin n_bad++; $display("FAIL small_latch_len: got %0d want %0d", wait_cyc, T_LATCH); end
    capture(1, 48, -1, 0);
    for (int b = 0; b < 48; b++) begin
      n_cmp++;
      if (wid[b] != exp_width(b, 12'h003, 8'h81, 3'b010)) begin
        n_bad++; $display("FAIL small_bit%0d: high %0d want %0d", b, wid[b], exp_width(b, 12'h003, 8'h81, 3'b010));
      end
    end
    n_cmp++; if (shape_bad || early_done || !done_seen) begin n_bad++; $display("FAIL small_frame: shape %b early %b done %b want 0 0 1", shape_bad, early_done, done_seen); end
  endtask

  initial begin
    test_reset();
    test_single_led();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    test_small_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
